hello_world_qsys_gpio: RTL and testbench

Parametrised Avalon-MM GPIO slave: the successor to the fixed 5-bit LED output port in the hello_world Qsys system. Provides a configurable-width output register with atomic set/clear, a synchronised input port with edge capture and a maskable interrupt, and a per-bit hardware blink prescaler. It sits on the Nios II data master bus next to the existing LED/switch peripherals.

---
 rtl/hello_world_qsys_gpio_pkg.sv | 23 ++
 rtl/hello_world_qsys_gpio_blink.sv | 42 ++++
 rtl/hello_world_qsys_gpio.sv | 136 +++++++++++++
 tb/tb_hello_world_qsys_gpio.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hello_world_qsys_gpio_pkg.sv
// Shared constants for the hello_world Qsys GPIO slave: register map and edge modes.
package hello_world_qsys_gpio_pkg;

  localparam logic [2:0] ADDR_OUT          = 3'd0;
  localparam logic [2:0] ADDR_IN           = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET       = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR       = 3'd5;
  localparam logic [2:0] ADDR_BLINK_MASK   = 3'd6;
  localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd7;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  typedef struct packed {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/hello_world_qsys_gpio_blink.sv
// Blink prescaler: free-running counter that toggles phase every period+1 clocks.
module hello_world_qsys_gpio_blink #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PRESCALE_W-1:0] period,
  input  logic                  load,
  output logic                  phase
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    // A period reload restarts the sequence so the first toggle lands period+1 clocks later.
    if (load || period == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == period) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/hello_world_qsys_gpio.sv
// Avalon-MM GPIO slave: output reg with set/clear, synchronised edge-capture inputs,
// maskable level irq and per-bit hardware blink.
module hello_world_qsys_gpio #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          PRESCALE_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);
  import hello_world_qsys_gpio_pkg::*;

  bus_req_t req;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;

  assign req.we    = chipselect & ~write_n;
  assign req.addr  = address;
  assign req.wdata = writedata;
  assign wd        = req.wdata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  logic [WIDTH-1:0]      data_out_q, data_out_d;
  logic [WIDTH-1:0]      irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0]      edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0]      blink_mask_q, blink_mask_d;
  logic [PRESCALE_W-1:0] blink_period_q, blink_period_d;
  logic [WIDTH-1:0]      s1_q, s2_q, s3_q;
  logic [1:0]            arm_q, arm_d;
  logic                  armed;
  logic [WIDTH-1:0]      edge_det;
  logic                  blink_load;
  logic                  phase;

  assign armed = (arm_q == 2'd3);

  // Per-bit edge detect on the settled s2/s3 pair; gated until the chain has filled.
  for (genvar i = 0; i < WIDTH; i++) begin : g_edge
    logic rise, fall, hit;
    assign rise = s2_q[i] & ~s3_q[i];
    assign fall = ~s2_q[i] & s3_q[i];
    if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
      assign hit = fall;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign hit = rise | fall;
    end else begin : g_rise
      assign hit = rise;
    end
    assign edge_det[i] = hit & armed;
  end

  always_comb begin
    data_out_d     = data_out_q;
    irq_mask_d     = irq_mask_q;
    blink_mask_d   = blink_mask_q;
    blink_period_d = blink_period_q;
    edge_cap_d     = edge_cap_q;
    arm_d          = armed ? arm_q : arm_q + 2'd1;
    blink_load     = 1'b0;
    if (req.we) begin
      case (req.addr)
        ADDR_OUT:          data_out_d   = wd;
        ADDR_IRQ_MASK:     irq_mask_d   = wd;
        ADDR_EDGE_CAP:     edge_cap_d   = edge_cap_q & ~wd;
        ADDR_OUTSET:       data_out_d   = data_out_q | wd;
        ADDR_OUTCLR:       data_out_d   = data_out_q & ~wd;
        ADDR_BLINK_MASK:   blink_mask_d = wd;
        ADDR_BLINK_PERIOD: begin
          blink_period_d = req.wdata[PRESCALE_W-1:0];
          blink_load     = 1'b1;
        end
        default: ;
      endcase
    end
    // OR-ing after the clear makes a same-cycle set win over W1C.
    edge_cap_d = edge_cap_d | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q     <= RESET_VALUE[WIDTH-1:0];
      irq_mask_q     <= '0;
      edge_cap_q     <= '0;
      blink_mask_q   <= '0;
      blink_period_q <= '0;
      s1_q           <= '0;
      s2_q           <= '0;
      s3_q           <= '0;
      arm_q          <= '0;
    end else begin
      data_out_q     <= data_out_d;
      irq_mask_q     <= irq_mask_d;
      edge_cap_q     <= edge_cap_d;
      blink_mask_q   <= blink_mask_d;
      blink_period_q <= blink_period_d;
      s1_q           <= in_port;
      s2_q           <= s1_q;
      s3_q           <= s2_q;
      arm_q          <= arm_d;
    end
  end

  hello_world_qsys_gpio_blink #(.PRESCALE_W(PRESCALE_W)) u_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (blink_period_q),
    .load    (blink_load),
    .phase   (phase)
  );

  assign out_port = data_out_q ^ (blink_mask_q & {WIDTH{phase}});
  assign irq      = |(edge_cap_q & irq_mask_q);

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_OUT:          readdata[WIDTH-1:0]      = data_out_q;
      ADDR_IN:           readdata[WIDTH-1:0]      = s2_q;
      ADDR_IRQ_MASK:     readdata[WIDTH-1:0]      = irq_mask_q;
      ADDR_EDGE_CAP:     readdata[WIDTH-1:0]      = edge_cap_q;
      ADDR_BLINK_MASK:   readdata[WIDTH-1:0]      = blink_mask_q;
      ADDR_BLINK_PERIOD: readdata[PRESCALE_W-1:0] = blink_period_q;
      default:           readdata                 = '0;
    endcase
  end

endmodule

// File: tb/tb_hello_world_qsys_gpio.sv
// Bench for hello_world_qsys_gpio: three instances (rising/falling/any) on a shared bus.
module tb_hello_world_qsys_gpio;
  import hello_world_qsys_gpio_pkg::*;

  localparam logic [7:0] RV = 8'hA5;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [2:0]      address = '0;
  logic            chipselect = 1'b0;
  logic            write_n = 1'b1;
  logic [31:0]     writedata = '0;
  logic [7:0]      in_port = '0;
  logic [2:0][31:0] rd;
  logic [2:0][7:0]  op;
  logic [2:0]       irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]      m_out;
  logic [7:0]      pin;
  logic [2:0][7:0] m_cap;
  logic [2:0][31:0] v;

  always #5 clk = ~clk;

  hello_world_qsys_gpio #(.WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(0), .PRESCALE_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd[0]), .in_port(in_port), .out_port(op[0]), .irq(irq[0]));
  hello_world_qsys_gpio #(.WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(1), .PRESCALE_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd[1]), .in_port(in_port), .out_port(op[1]), .irq(irq[1]));
  hello_world_qsys_gpio #(.WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(2), .PRESCALE_W(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd[2]), .in_port(in_port), .out_port(op[2]), .irq(irq[2]));

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [2:0][31:0] r);
    address = a;
    #1;
    r = rd;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Blink phase after n clocks since a period-p load: toggles every p+1 clocks.
  function automatic logic blink_ph(input int n, input int p);
    return ((n / (p + 1)) % 2) == 1;
  endfunction

  task automatic test_reset;
    reset_n = 1'b0; in_port = 8'hFF;
    #12;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (op[k] !== RV) begin n_fail++; $display("FAIL reset_out[%0d]: got %h exp %h", k, op[k], RV); end
      n_checks++;
      if (irq[k] !== 1'b0) begin n_fail++; $display("FAIL reset_irq[%0d]: got %b exp 0", k, irq[k]); end
    end
    bus_read(ADDR_OUT, v);
    n_checks++;
    if (v[0] !== 32'hA5) begin n_fail++; $display("FAIL reset_rd_out: got %h exp %h", v[0], 32'hA5); end
    // Inputs held high through release must not look like an edge.
    @(negedge clk); reset_n = 1'b1;
    bus_write(ADDR_IRQ_MASK, 32'hFF);
    cycles(5);
    bus_read(ADDR_EDGE_CAP, v);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (irq[k] !== 1'b0) begin n_fail++; $display("FAIL arm_irq[%0d]: got %b exp 0", k, irq[k]); end
      n_checks++;
      if (v[k] !== 32'h0) begin n_fail++; $display("FAIL arm_cap[%0d]: got %h exp 0", k, v[k]); end
    end
    bus_write(ADDR_IRQ_MASK, 32'h0);
    in_port = 8'h00;
    cycles(4);
    bus_write(ADDR_EDGE_CAP, 32'hFF);
    pin = 8'h00; m_cap = '0; m_out = RV;
  endtask

  task automatic test_out_set_clr;
    logic [31:0] d;
    int sel;
    bus_write(ADDR_OUT, 32'h0F);
    bus_write(ADDR_OUTSET, 32'hF0);
    bus_write(ADDR_OUTCLR, 32'h81);
    m_out = 8'h7E;
    @(negedge clk);
    n_checks++;
    if (op[0] !== 8'h7E) begin n_fail++; $display("FAIL setclr_out: got %h exp 7e", op[0]); end
    bus_read(ADDR_OUT, v);
    n_checks++;
    if (v[0] !== 32'h7E) begin n_fail++; $display("FAIL setclr_rd0: got %h exp 7e", v[0]); end
    bus_read(ADDR_OUTSET, v);
    n_checks++;
    if (v[0] !== 32'h0) begin n_fail++; $display("FAIL rd_outset: got %h exp 0", v[0]); end
    bus_read(ADDR_OUTCLR, v);
    n_checks++;
    if (v[0] !== 32'h0) begin n_fail++; $display("FAIL rd_outclr: got %h exp 0", v[0]); end
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      sel = $urandom_range(0, 2);
      case (sel)
        0: begin bus_write(ADDR_OUT, d);    m_out = d[7:0]; end
        1: begin bus_write(ADDR_OUTSET, d); m_out = m_out | d[7:0]; end
        default: begin bus_write(ADDR_OUTCLR, d); m_out = m_out & ~d[7:0]; end
      endcase
      bus_read(ADDR_OUT, v);
      n_checks++;
      if (op[1] !== m_out) begin n_fail++; $display("FAIL rand_out[%0d]: got %h exp %h", i, op[1], m_out); end
      n_checks++;
      if (v[1] !== {24'h0, m_out}) begin n_fail++; $display("FAIL rand_rd[%0d]: got %h exp %h", i, v[1], m_out); end
    end
  endtask

  task automatic test_upper_bits;
    bus_write(ADDR_OUT, 32'hFFFF_FF00);
    m_out = 8'h00;
    bus_read(ADDR_OUT, v);
    n_checks++;
    if (op[0] !== 8'h00) begin n_fail++; $display("FAIL upper_out: got %h exp 00", op[0]); end
    n_checks++;
    if (v[0] !== 32'h0) begin n_fail++; $display("FAIL upper_rd: got %h exp 0", v[0]); end
  endtask

  task automatic test_rise_irq;
    bus_write(ADDR_IRQ_MASK, 32'h04);
    @(negedge clk); in_port[2] = 1'b1; pin = in_port;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (irq[0] !== (e == 3)) begin n_fail++; $display("FAIL rise_irq_e%0d: got %b exp %b", e, irq[0], e == 3); end
    end
    n_checks++;
    if (irq[1] !== 1'b0) begin n_fail++; $display("FAIL rise_irq_fallmode: got %b exp 0", irq[1]); end
    n_checks++;
    if (irq[2] !== 1'b1) begin n_fail++; $display("FAIL rise_irq_anymode: got %b exp 1", irq[2]); end
    bus_read(ADDR_EDGE_CAP, v);
    n_checks++;
    if (v[0] !== 32'h04) begin n_fail++; $display("FAIL rise_cap: got %h exp 04", v[0]); end
    n_checks++;
    if (v[1] !== 32'h00) begin n_fail++; $display("FAIL rise_cap_fallmode: got %h exp 00", v[1]); end
  endtask

  task automatic test_w1c;
    bus_write(ADDR_EDGE_CAP, 32'h04);
    @(negedge clk);
    n_checks++;
    if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL w1c_irq: got %b exp 0", irq[0]); end
    bus_read(ADDR_EDGE_CAP, v);
    n_checks++;
    if (v[2] !== 32'h0) begin n_fail++; $display("FAIL w1c_cap: got %h exp 0", v[2]); end
  endtask

  task automatic test_falling;
    @(negedge clk); in_port[2] = 1'b0; pin = in_port;
    cycles(3);
    @(negedge clk);
    n_checks++;
    if (irq !== 3'b110) begin n_fail++; $display("FAIL fall_irq: got %b exp 110", irq); end
    bus_read(ADDR_EDGE_CAP, v);
    n_checks++;
    if (v[1] !== 32'h04) begin n_fail++; $display("FAIL fall_cap: got %h exp 04", v[1]); end
    n_checks++;
    if (v[0] !== 32'h00) begin n_fail++; $display("FAIL fall_cap_risemode: got %h exp 00", v[0]); end
    bus_write(ADDR_EDGE_CAP, 32'hFF);
  endtask

  task automatic test_collision;
    // Edge on bit 2 reaches edge_cap at the same clock that samples the W1C.
    @(negedge clk); in_port[2] = 1'b1; pin = in_port;
    repeat (2) @(posedge clk);
    @(negedge clk);
    address = ADDR_EDGE_CAP; writedata = 32'h04; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    bus_read(ADDR_EDGE_CAP, v);
    n_checks++;
    if (v[0] !== 32'h04) begin n_fail++; $display("FAIL collide_cap: got %h exp 04", v[0]); end
    n_checks++;
    if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL collide_irq: got %b exp 1", irq[0]); end
    bus_write(ADDR_EDGE_CAP, 32'hFF);
    bus_read(ADDR_EDGE_CAP, v);
    n_checks++;
    if (v[0] !== 32'h0) begin n_fail++; $display("FAIL collide_clear: got %h exp 0", v[0]); end
    m_cap = '0;
  endtask

  task automatic test_random_edges;
    logic [7:0] nv, m, w;
    for (int i = 0; i < 8; i++) begin
      nv = 8'($urandom); m = 8'($urandom);
      bus_write(ADDR_IRQ_MASK, {24'h0, m});
      @(negedge clk); in_port = nv;
      m_cap[0] = m_cap[0] | (nv & ~pin);
      m_cap[1] = m_cap[1] | (~nv & pin);
      m_cap[2] = m_cap[2] | (nv ^ pin);
      pin = nv;
      cycles(4);
      bus_read(ADDR_IN, v);
      n_checks++;
      if (v[0] !== {24'h0, nv}) begin n_fail++; $display("FAIL rnd_in[%0d]: got %h exp %h", i, v[0], nv); end
      bus_read(ADDR_EDGE_CAP, v);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (v[k] !== {24'h0, m_cap[k]}) begin n_fail++; $display("FAIL rnd_cap[%0d][%0d]: got %h exp %h", i, k, v[k], m_cap[k]); end
        n_checks++;
        if (irq[k] !== |(m_cap[k] & m)) begin n_fail++; $display("FAIL rnd_irq[%0d][%0d]: got %b exp %b", i, k, irq[k], |(m_cap[k] & m)); end
      end
      w = 8'($urandom);
      bus_write(ADDR_EDGE_CAP, {24'hFFFFFF, w});
      for (int k = 0; k < 3; k++) m_cap[k] = m_cap[k] & ~w;
    end
    bus_write(ADDR_IRQ_MASK, 32'h0);
    bus_write(ADDR_EDGE_CAP, 32'hFF);
    m_cap = '0;
  endtask

  task automatic test_blink;
    logic [7:0] d, bm, ex;
    int p;
    bus_write(ADDR_OUT, 32'h0);
    bus_write(ADDR_BLINK_MASK, 32'h01);
    bus_write(ADDR_BLINK_PERIOD, 32'd3);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      ex = {7'h0, blink_ph(n, 3)};
      n_checks++;
      if (op[0] !== ex) begin n_fail++; $display("FAIL blink3_n%0d: got %h exp %h", n, op[0], ex); end
      @(posedge clk);
    end
    p = $urandom_range(1, 5);
    d = 8'($urandom); bm = 8'($urandom);
    bus_write(ADDR_OUT, {24'h0, d});
    bus_write(ADDR_BLINK_MASK, {24'h0, bm});
    bus_write(ADDR_BLINK_PERIOD, 32'(p));
    bus_read(ADDR_BLINK_PERIOD, v);
    n_checks++;
    if (v[0] !== 32'(p)) begin n_fail++; $display("FAIL blink_rd_period: got %h exp %h", v[0], p); end
    for (int n = 0; n < 4 * (p + 1) + 2; n++) begin
      @(negedge clk);
      ex = d ^ (bm & {8{blink_ph(n, p)}});
      n_checks++;
      if (op[0] !== ex) begin n_fail++; $display("FAIL blinkr_p%0d_n%0d: got %h exp %h", p, n, op[0], ex); end
      @(posedge clk);
    end
    bus_write(ADDR_OUT, 32'h0);
    bus_write(ADDR_BLINK_PERIOD, 32'h0);
    m_out = 8'h00;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      n_checks++;
      if (op[0] !== 8'h00) begin n_fail++; $display("FAIL blink0_n%0d: got %h exp 00", n, op[0]); end
    end
  endtask

  task automatic test_mid_reset;
    bus_write(ADDR_BLINK_MASK, 32'hFF);
    bus_write(ADDR_BLINK_PERIOD, 32'd2);
    bus_write(ADDR_IRQ_MASK, 32'hFF);
    @(negedge clk); in_port = ~pin; pin = in_port;
    cycles(5);
    @(negedge clk);
    n_checks++;
    if (irq[2] !== 1'b1) begin n_fail++; $display("FAIL mid_pre_irq: got %b exp 1", irq[2]); end
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (op[k] !== RV) begin n_fail++; $display("FAIL mid_out[%0d]: got %h exp %h", k, op[k], RV); end
      n_checks++;
      if (irq[k] !== 1'b0) begin n_fail++; $display("FAIL mid_irq[%0d]: got %b exp 0", k, irq[k]); end
    end
    bus_read(ADDR_EDGE_CAP, v);
    n_checks++;
    if (v[2] !== 32'h0) begin n_fail++; $display("FAIL mid_cap: got %h exp 0", v[2]); end
    bus_read(ADDR_BLINK_PERIOD, v);
    n_checks++;
    if (v[0] !== 32'h0) begin n_fail++; $display("FAIL mid_period: got %h exp 0", v[0]); end
    bus_read(ADDR_IRQ_MASK, v);
    n_checks++;
    if (v[0] !== 32'h0) begin n_fail++; $display("FAIL mid_mask: got %h exp 0", v[0]); end
    @(negedge clk); reset_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      n_checks++;
      if (op[0] !== RV) begin n_fail++; $display("FAIL mid_post_n%0d: got %h exp %h", n, op[0], RV); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_out_set_clr();
    test_upper_bits();
    test_rise_irq();
    test_w1c();
    test_falling();
    test_collision();
    test_random_edges();
    test_blink();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
